// File: rtl/lutn_cfg_pkg.sv
// Shared definitions for the configurable LUT: the load FSM encoding and
// the legal range of the LUT input count.
package lutn_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam int K_MIN = 2;
  localparam int K_MAX = 8;

endpackage

// File: rtl/lutn_rdmux.sv
// Parametrised 2**K:1 read mux used to read one bit of a LUT truth table.
module lutn_rdmux #(
  parameter int K = 4
) (
  input  logic [(2**K)-1:0] tbl_i,
  input  logic [K-1:0]      sel_i,
  output logic              bit_o
);

  assign bit_o = tbl_i[sel_i];

endmodule

// File: rtl/lutn_cfg.sv
// K-input LUT whose truth table is loaded serially into a shadow copy and
// swapped into the active table in a single cycle, so Z never sees a mix.
module lutn_cfg
  import lutn_cfg_pkg::*;
#(
  parameter int                 K       = 4,
  parameter logic [(2**K)-1:0]  INIT    = '0,
  parameter bit                 REG_OUT = 1'b0
) (
  input  logic         CK,
  input  logic         RSTN,
  input  logic [K-1:0] ADDR,
  input  logic         CE,
  output logic         Z,
  input  logic         CFG_START,
  input  logic         CFG_VALID,
  input  logic         CFG_DI,
  output logic         CFG_READY,
  output logic         CFG_DO,
  output logic         CFG_DONE
);

  localparam int N = 2**K;

  if ((K < K_MIN) || (K > K_MAX)) begin : g_bad_k
    $error("lutn_cfg: K out of range");
  end

  state_e         state_q, state_d;
  logic [K:0]     count_q, count_d;
  logic [N-1:0]   shadow_q, shadow_d;
  logic [N-1:0]   active_q, active_d;
  logic           ready_q;
  logic           done_q;
  logic           z_raw_s;
  logic           do_raw_s;
  logic [K-1:0]   idx_s;

  assign idx_s = count_q[K-1:0];

  // Load FSM next-state: collect bits into the shadow, then swap in COMMIT.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    active_d = active_q;
    case (state_q)
      IDLE: begin
        if (CFG_START) begin
          state_d = LOAD;
          count_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        // A restart wins over a bit presented in the same cycle.
        if (CFG_START) begin
          count_d = '0;
        end else if (CFG_VALID) begin
          shadow_d[idx_s] = CFG_DI;
          count_d         = count_q + {{K{1'b0}}, 1'b1};
          if (idx_s == {K{1'b1}}) begin
            state_d = COMMIT;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      COMMIT: begin
        active_d = shadow_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // State, tables and handshake outputs; reset restores the INIT table.
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      state_q  <= IDLE;
      count_q  <= '0;
      shadow_q <= '0;
      active_q <= INIT;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      ready_q  <= (state_d == LOAD);
      done_q   <= (state_d == COMMIT);
    end
  end

  lutn_rdmux #(.K(K)) u_zmux (
    .tbl_i (active_q),
    .sel_i (ADDR),
    .bit_o (z_raw_s)
  );

  lutn_rdmux #(.K(K)) u_domux (
    .tbl_i (active_q),
    .sel_i (idx_s),
    .bit_o (do_raw_s)
  );

  assign CFG_READY = ready_q;
  assign CFG_DONE  = done_q;
  assign CFG_DO    = (state_q == LOAD) ? do_raw_s : 1'b0;

  if (REG_OUT) begin : g_zreg
    logic z_q;

    // Output register: captures the LUT value only on CE cycles.
    always_ff @(posedge CK) begin
      if (!RSTN) begin
        z_q <= 1'b0;
      end else if (CE) begin
        z_q <= z_raw_s;
      end else begin
        z_q <= z_q;
      end
    end

    assign Z = z_q;
  end else begin : g_zcomb
    logic unused_ce;
    assign unused_ce = CE;
    assign Z         = z_raw_s;
  end

endmodule

// File: tb/tb_lutn_cfg.sv
// Self-checking bench for lutn_cfg: directed table sweeps and load sequences
// plus randomized traffic, all compared against a queue-based model.
module tb_lutn_cfg;

  localparam logic [15:0] INIT_TBL = 16'h8000;

  logic       CK = 1'b0;
  logic       RSTN = 1'b0;
  logic [3:0] ADDR = 4'd0;
  logic       CE = 1'b0;
  logic       CFG_START = 1'b0;
  logic       CFG_VALID = 1'b0;
  logic       CFG_DI = 1'b0;
  logic       z_c, z_r;
  logic       rdy_c, rdy_r, do_c, do_r, done_c, done_r;

  int checks = 0;
  int errs   = 0;
  int done_seen = 0;

  always #5 CK = ~CK;

  lutn_cfg #(.K(4), .INIT(INIT_TBL), .REG_OUT(1'b0)) dut (
    .CK(CK), .RSTN(RSTN), .ADDR(ADDR), .CE(CE), .Z(z_c),
    .CFG_START(CFG_START), .CFG_VALID(CFG_VALID), .CFG_DI(CFG_DI),
    .CFG_READY(rdy_c), .CFG_DO(do_c), .CFG_DONE(done_c)
  );

  lutn_cfg #(.K(4), .INIT(INIT_TBL), .REG_OUT(1'b1)) dut_r (
    .CK(CK), .RSTN(RSTN), .ADDR(ADDR), .CE(CE), .Z(z_r),
    .CFG_START(CFG_START), .CFG_VALID(CFG_VALID), .CFG_DI(CFG_DI),
    .CFG_READY(rdy_r), .CFG_DO(do_r), .CFG_DONE(done_r)
  );

  // Behavioural model: a table, a queue of received bits, and two flags.
  logic [15:0] m_active;
  bit          m_loading;
  bit          m_committing;
  bit          m_bits[$];
  logic        m_zr;

  typedef struct {
    logic [3:0] addr;
    logic       z_init;
    logic       z_par;
    logic       z_fffe;
  } vec_t;
  vec_t vecs[16];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [15:0] t;
    if (!RSTN) begin
      m_active = INIT_TBL; m_loading = 0; m_committing = 0;
      m_bits.delete(); m_zr = 1'b0;
    end else begin
      if (CE) m_zr = m_active[ADDR];
      if (m_committing) begin
        t = '0;
        foreach (m_bits[i]) t[i] = m_bits[i];
        m_active = t; m_committing = 0; m_bits.delete();
      end else if (m_loading) begin
        if (CFG_START) m_bits.delete();
        else if (CFG_VALID) begin
          m_bits.push_back(CFG_DI);
          if (m_bits.size() == 16) begin m_loading = 0; m_committing = 1; end
        end
      end else if (CFG_START) begin
        m_loading = 1; m_bits.delete();
      end
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising one.
  task automatic tick();
    @(negedge CK);
    chk("z_comb",  z_c,    m_active[ADDR]);
    chk("z_reg",   z_r,    m_zr);
    chk("ready",   rdy_c,  m_loading);
    chk("done",    done_c, m_committing);
    chk("cfg_do",  do_c,   m_loading ? m_active[m_bits.size()] : 1'b0);
    chk("ready_r", rdy_r,  m_loading);
    chk("done_r",  done_r, m_committing);
    if (done_c) done_seen++;
    @(posedge CK);
    model_edge();
    #1;
  endtask

  task automatic load_word(input logic [15:0] w, input bit gaps, input int nbits);
    CFG_START = 1'b1; CFG_VALID = 1'b0; tick();
    CFG_START = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      CFG_VALID = 1'b1; CFG_DI = w[i]; ADDR = 4'($urandom); tick();
      if (gaps) begin CFG_VALID = 1'b0; CFG_DI = ~w[i]; tick(); end
    end
    CFG_VALID = 1'b0;
  endtask

  task automatic sweep(input int which);
    for (int i = 0; i < 16; i++) begin
      ADDR = vecs[i].addr;
      tick();
      case (which)
        0: chk("sweep_init", z_c, vecs[i].z_init);
        1: chk("sweep_par",  z_c, vecs[i].z_par);
        default: chk("sweep_fffe", z_c, vecs[i].z_fffe);
      endcase
    end
  endtask

  initial begin
    logic [15:0] w6996, wfffe, w0001;
    logic [3:0]  a;
    w6996 = 16'h6996; wfffe = 16'hFFFE; w0001 = 16'h0001;
    for (int i = 0; i < 16; i++) begin
      a = 4'(i);
      vecs[i].addr   = a;
      vecs[i].z_init = (i == 15);
      vecs[i].z_par  = ^a;
      vecs[i].z_fffe = (i != 0);
    end

    // Reset
    repeat (2) @(posedge CK);
    model_edge();
    #1;
    RSTN = 1'b1;
    chk("rst_ready", rdy_c, 1'b0);
    chk("rst_done",  done_c, 1'b0);
    chk("rst_zr",    z_r, 1'b0);
    sweep(0);

    // Contiguous load of the XOR table; DONE one cycle after the last bit
    done_seen = 0;
    load_word(w6996, 1'b0, 16);
    chk("done_after_last_bit", done_c, 1'b1);
    tick();
    sweep(1);
    chk("single_done_6996", 1'(done_seen == 1), 1'b1);

    // Back to INIT, then a gapped load of the same table
    RSTN = 1'b0; tick(); RSTN = 1'b1; tick();
    done_seen = 0;
    load_word(w6996, 1'b1, 16);
    tick();
    chk("single_done_gap", 1'(done_seen == 1), 1'b1);
    sweep(1);

    // Aborted after 7 bits, restarted with FFFE
    done_seen = 0;
    load_word(16'h007F, 1'b0, 7);
    load_word(wfffe, 1'b0, 16);
    repeat (2) tick();
    chk("single_done_restart", 1'(done_seen == 1), 1'b1);
    sweep(2);

    // Reset in the middle of a load
    done_seen = 0;
    load_word(w0001, 1'b0, 10);
    RSTN = 1'b0; tick(); RSTN = 1'b1;
    repeat (20) tick();
    chk("no_done_after_rst", 1'(done_seen == 0), 1'b1);
    sweep(0);

    // Registered output: hold with CE=0, update one cycle after a CE edge
    ADDR = 4'hF; CE = 1'b0; tick(); tick();
    chk("zr_hold", z_r, 1'b0);
    CE = 1'b1; tick();
    CE = 1'b0; ADDR = 4'h0;
    chk("zr_update", z_r, 1'b1);
    tick();
    chk("zr_hold2", z_r, 1'b1);
    CE = 1'b1; tick();
    chk("zr_update2", z_r, 1'b0);

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      RSTN      = ($urandom_range(0, 199) != 0);
      CFG_START = ($urandom_range(0, 59) == 0);
      CFG_VALID = ($urandom_range(0, 3) != 0);
      CFG_DI    = 1'($urandom);
      CE        = 1'($urandom);
      ADDR      = 4'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/lutn_cfg.md
LUTN_CFG -- requirements
Module: lutn_cfg

Interface
REQ-001 SHALL have parameter K, default 4, meaning number of LUT inputs, legal range 2..8.
REQ-002 SHALL have parameter INIT, default all zeros, width 2**K, meaning power-up and reset truth table; bit i is the output for ADDR==i.
REQ-003 SHALL have parameter REG_OUT, default 0, meaning 0 for combinational Z and 1 for Z registered with CE.
REQ-004 SHALL have port CK, input, width 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RSTN, input, width 1, reset that is synchronous and active-low.
REQ-006 SHALL have port ADDR, input, width K, LUT select inputs (bit 0 = A).
REQ-007 SHALL have port CE, input, width 1, output-register enable; ignored when REG_OUT=0.
REQ-008 SHALL have port Z, output, width 1, the LUT output.
REQ-009 SHALL have port CFG_START, input, width 1, a pulse that begins a truth-table load.
REQ-010 SHALL have port CFG_VALID, input, width 1, qualifying CFG_DI.
REQ-011 SHALL have port CFG_DI, input, width 1, serial configuration data, LSB first.
REQ-012 SHALL have port CFG_READY, output, width 1, high while a bit can be accepted.
REQ-013 SHALL have port CFG_DO, output, width 1, readback of the active-table bit at the current load index.
REQ-014 SHALL have port CFG_DONE, output, width 1, a one-cycle pulse when a new table is committed.

Function
REQ-015 SHALL hold an active table (2**K bits), a shadow table (2**K bits) and a bit counter (K+1 bits).
REQ-016 Z SHALL equal active[ADDR] combinationally when REG_OUT=0, and SHALL register active[ADDR] on each CK edge with CE=1 when REG_OUT=1 (latency 1).
REQ-017 The FSM SHALL have three states: IDLE, LOAD and COMMIT.
REQ-018 IDLE: CFG_START=1 SHALL move the FSM to LOAD with count=0.
REQ-019 IDLE: CFG_READY SHALL be 0, and CFG_VALID SHALL be ignored.
REQ-020 LOAD: CFG_READY SHALL be 1.
REQ-021 LOAD: each cycle with CFG_VALID=1 SHALL set shadow[count]<=CFG_DI and increment count; gaps with CFG_VALID=0 SHALL hold state.
REQ-022 LOAD: accepting the bit at count==2**K-1 SHALL move the FSM to COMMIT.
REQ-023 LOAD: CFG_START=1 SHALL abort and restart the load with count=0, leave active untouched, and discard any CFG_VALID in that same cycle.
REQ-024 COMMIT, for exactly one cycle: active<=shadow, CFG_DONE=1 and CFG_READY=0, with CFG_START ignored; the next state SHALL be IDLE.
REQ-025 Z SHALL reflect the old table through the COMMIT cycle and the new table from the following cycle (REG_OUT=0).
REQ-026 CFG_DO SHALL equal active[count[K-1:0]] in LOAD and 0 otherwise.
REQ-027 The active table SHALL never be partially updated.

Reset
REQ-028 With RSTN=0 at a CK edge, the block SHALL set active<=INIT, shadow<=0, count<=0 and state<=IDLE.
REQ-029 With RSTN=0 at a CK edge, the block SHALL set CFG_DONE<=0, CFG_READY<=0 and the Z register (REG_OUT=1) <=0.
REQ-030 Reset during LOAD or COMMIT SHALL abandon the load, with no commit and active==INIT.
REQ-031 RSTN SHALL override CFG_START, CFG_VALID and CE in the same cycle.

Structure
REQ-032 Package lutn_cfg_pkg SHALL hold the FSM state encoding (IDLE=2'd0, LOAD=2'd1, COMMIT=2'd2) and the K range limits (K_MIN=2, K_MAX=8).
REQ-033 One sub-module, lutn_rdmux, SHALL implement the parametrised 2**K:1 read mux and SHALL be instantiated twice: once for Z and once for CFG_DO.

Verification
REQ-034 K=4, INIT=16'h8000: sweep ADDR 0..15 -> Z=1 only at ADDR=4'hF.
REQ-035 START at cycle 0, then 16 consecutive valid bits of 16'h6996 in cycles 1..16 -> CFG_DONE=1 at cycle 17, Z=^ADDR from cycle 18, and CFG_DO returns 16'h8000 bits during the load.
REQ-036 A load with CFG_VALID gaps (every other cycle) -> identical commit after 32 data cycles, with Z unchanged until the commit.
REQ-037 START, 7 bits, then START again with 16 bits of 16'hFFFE -> a single CFG_DONE, and Z=0 only at ADDR=0.
REQ-038 RSTN=0 at bit 10 of a load of 16'h0001 -> no CFG_DONE, and Z follows 16'h8000 after reset.
REQ-039 REG_OUT=1, CE toggling: a change in ADDR -> Z updates exactly one cycle after an edge with CE=1, and holds while CE=0.
